increment_program_counter: RTL and testbench
============================================

Name: increment_program_counter

Overview:
- 5-bit program counter with a built-in 4-phase timing sequencer.
- A 4-bit one-hot shift register marks the instruction phases.
- On the last phase the PC loads its incremented value from a 5-bit ripple-carry adder.
- Sits in the fetch stage; exposes the phase register and the next-PC (adder) value.

Parameters:
- PC_W, 5, program counter / adder width.
- PHASES, 4, shift-register length (instruction cycle length in clocks).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
- I  input  5  PC start value, declared [0:4]: I[0] is MSB, I[4] is LSB; read only while reset is asserted.
- sh_reg_out  output  4  one-hot phase register [3:0].
- adder_out  output  5  combinational PC + 1, [4:0] MSB first.

Behaviour:
- Internal state: pc[4:0] and sh[3:0]; sh_reg_out = sh.
- adder_out = (pc + 1) mod 32, purely combinational, no added latency; carry-out discarded.
- Reset, on a rising clk with reset==0:
  - pc <= I, with I[0]->pc[4] and I[4]->pc[0].
  - sh <= 4'b0001.
  - Reset has priority over everything and works mid-operation.
  - While reset is held low, outputs stay at sh_reg_out=0001 and adder_out=I+1, tracking I on each edge.
- Run, on a rising clk with reset==1:
  - If sh==4'b1000: pc <= adder_out and sh <= 4'b0001 (rotate).
  - Otherwise sh <= sh<<1 and pc holds.
  - The PC therefore advances exactly once per 4 clocks; the first increment occurs on the 4th rising edge after reset deasserts.
- I is ignored when not in reset.
- Wrap: pc=11111 -> adder_out=00000; the next step loads 00000.
- sh can never be outside the four one-hot codes. If it is corrupted to any other value, the next edge forces sh <= 0001 with pc held.
- Adder is a 5-stage ripple-carry chain of full adders, B operand constant 00001, carry-in 0.

Optional Feature:
- Macro IPC_SINGLE_CYCLE_STEP_EN.
- Defined:
  - The sequencer is bypassed for stepping: pc <= adder_out on every non-reset rising edge.
  - sh still rotates and is still reported.
- Undefined: pc steps only on phase 1000, as above.
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package ipc_pkg:
  - PC_W, PHASES.
  - Constants PHASE_FIRST=4'b0001, PHASE_LAST=4'b1000, INC_ONE=5'b00001.
  - Typedef pc_t (logic [PC_W-1:0]).
- One natural sub-module: ipc_ripple_adder, a 5-bit ripple-carry adder built from full-adder cells.
  - Inputs a, b, cin; outputs sum, cout.
  - Instantiated once with b=INC_ONE, cin=0.

Test Plan:
- I=00100, reset held 0 for 25 clocks -> sh_reg_out=0001 and adder_out=00101 throughout.
- I=00100; reset 0 for 2 edges, then 1:
  - Edges 1-3 after release give sh=0010, 0100, 1000 with adder_out=00101.
  - Edge 4 gives sh=0001, adder_out=00110.
  - Edge 8 gives adder_out=00111.
- I=11110, release reset, run 8 clocks:
  - adder_out is 11111 until the first step, then 00000 (pc=11111), then 00001 after the second step (wrap).
- Reset mid-run:
  - Run 6 clocks from I=00000, set I=01010, pull reset low for 1 edge.
  - Result: sh=0001, adder_out=01011 on that edge; sequence restarts.
- Change I while reset=1 (00100 -> 11111) -> no effect on adder_out or sh.
- With IPC_SINGLE_CYCLE_STEP_EN, I=00100, release reset -> adder_out goes 00110, 00111, 01000 on consecutive edges while sh rotates.

Source files
------------

// File: rtl/ipc_pkg.sv
// Shared definitions for the increment_program_counter block: datapath
// width, sequencer length and the fixed phase / increment constants.
package ipc_pkg;

  localparam int PC_W   = 5;
  localparam int PHASES = 4;

  localparam logic [PHASES-1:0] PHASE_FIRST = 4'b0001;
  localparam logic [PHASES-1:0] PHASE_LAST  = 4'b1000;
  localparam logic [PC_W-1:0]   INC_ONE     = 5'b00001;

  typedef logic [PC_W-1:0] pc_t;

endpackage : ipc_pkg

// File: rtl/ipc_ripple_adder.sv
// PC_W-bit ripple-carry adder: a chain of full-adder cells, each stage
// taking the carry out of the stage below it.
module ipc_ripple_adder
  import ipc_pkg::*;
(
  input  logic [PC_W-1:0] a,
  input  logic [PC_W-1:0] b,
  input  logic            cin,
  output logic [PC_W-1:0] sum,
  output logic            cout
);

  // carry[k] is the carry into stage k; carry[PC_W] leaves the chain.
  logic [PC_W:0] carry;

  assign carry[0] = cin;

  for (genvar k = 0; k < PC_W; k++) begin : g_fa
    // Full-adder cell for bit k.
    assign sum[k]     = a[k] ^ b[k] ^ carry[k];
    assign carry[k+1] = (a[k] & b[k]) | (a[k] & carry[k]) | (b[k] & carry[k]);
  end

  assign cout = carry[PC_W];

endmodule : ipc_ripple_adder

// File: rtl/increment_program_counter.sv
// Fetch-stage program counter with a built-in 4-phase one-hot sequencer.
// The PC loads its ripple-adder increment once per instruction cycle, on
// the last phase. Build option IPC_SINGLE_CYCLE_STEP_EN makes the PC step
// on every non-reset edge while the phase register keeps rotating.
module increment_program_counter
  import ipc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,       // synchronous, active low
  input  logic [0:PC_W-1]     I,           // I[0] is the MSB
  output logic [PHASES-1:0]   sh_reg_out,
  output logic [PC_W-1:0]     adder_out
);

  pc_t               pc_q, pc_d;
  logic [PHASES-1:0] sh_q, sh_d;
  pc_t               start_pc;
  logic              unused_cout;

  // I is declared ascending; reverse it explicitly so I[0] lands on the PC MSB.
  for (genvar k = 0; k < PC_W; k++) begin : g_start
    assign start_pc[PC_W-1-k] = I[k];
  end

  ipc_ripple_adder u_adder (
    .a    (pc_q),
    .b    (INC_ONE),
    .cin  (1'b0),
    .sum  (adder_out),
    .cout (unused_cout)
  );

  // Run-mode next state: rotate the phase, step the PC on the last phase,
  // and recover any non-one-hot phase value to the first phase.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    pc_d = pc_q;
    sh_d = sh_q;
    unique case (sh_q)
      4'b0001, 4'b0010, 4'b0100: sh_d = sh_q << 1;
      PHASE_LAST: begin
        sh_d = PHASE_FIRST;
        pc_d = adder_out;
      end
      default: sh_d = PHASE_FIRST;
    endcase
`ifdef IPC_SINGLE_CYCLE_STEP_EN
    pc_d = adder_out;
`endif
  end

  // State registers; reset loads the start PC from I and the first phase.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      pc_q <= start_pc;
      sh_q <= PHASE_FIRST;
    end else begin
      pc_q <= pc_d;
      sh_q <= sh_d;
    end
  end

  assign sh_reg_out = sh_q;

endmodule : increment_program_counter

// File: tb/tb_increment_program_counter.sv
// Directed self-checking bench for increment_program_counter.
module tb_increment_program_counter;

  logic       clk;
  logic       reset;
  logic [0:4] I;
  logic [3:0] sh_reg_out;
  logic [4:0] adder_out;

  int checks   = 0;
  int failures = 0;

  increment_program_counter dut (
    .clk        (clk),
    .reset      (reset),
    .I          (I),
    .sh_reg_out (sh_reg_out),
    .adder_out  (adder_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected phase k edges after reset release.
  function automatic logic [3:0] exp_sh(input int k);
    return 4'b0001 << (k % 4);
  endfunction

  // Expected adder output k edges after release from start PC p.
  function automatic logic [4:0] exp_add(input logic [4:0] p, input int k);
`ifdef IPC_SINGLE_CYCLE_STEP_EN
    return 5'(p + 5'd1 + 5'(k));
`else
    return 5'(p + 5'd1 + 5'(k / 4));
`endif
  endfunction

  task automatic run_checks(input string tag, input logic [4:0] p, input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      check($sformatf("%s_sh%0d", tag, k), {4'b0, sh_reg_out}, {4'b0, exp_sh(k)});
      check($sformatf("%s_add%0d", tag, k), {3'b0, adder_out}, {3'b0, exp_add(p, k)});
    end
  endtask

  initial begin
    reset = 1'b0;
    I     = 5'b00100;

    // Reset held low: outputs pinned.
    for (int k = 0; k < 25; k++) begin
      step();
      check("hold_sh", {4'b0, sh_reg_out}, 8'b0000_0001);
      check("hold_add", {3'b0, adder_out}, 8'b0000_0101);
    end

    // Release from 00100, hand-checked key edges.
    reset = 1'b1;
    step();
    check("rel_e1_sh", {4'b0, sh_reg_out}, 8'b0000_0010);
`ifdef IPC_SINGLE_CYCLE_STEP_EN
    check("rel_e1_add", {3'b0, adder_out}, 8'b0000_0110);
`else
    check("rel_e1_add", {3'b0, adder_out}, 8'b0000_0101);
`endif
    step();
    check("rel_e2_sh", {4'b0, sh_reg_out}, 8'b0000_0100);
    step();
    check("rel_e3_sh", {4'b0, sh_reg_out}, 8'b0000_1000);
`ifdef IPC_SINGLE_CYCLE_STEP_EN
    check("rel_e3_add", {3'b0, adder_out}, 8'b0000_1000);
`else
    check("rel_e3_add", {3'b0, adder_out}, 8'b0000_0101);
`endif
    step();
    check("rel_e4_sh", {4'b0, sh_reg_out}, 8'b0000_0001);
`ifdef IPC_SINGLE_CYCLE_STEP_EN
    check("rel_e4_add", {3'b0, adder_out}, 8'b0000_1001);
`else
    check("rel_e4_add", {3'b0, adder_out}, 8'b0000_0110);
`endif
    // I changes while running must be ignored.
    I = 5'b11111;
    for (int k = 5; k <= 8; k++) begin
      step();
      check($sformatf("ign_sh%0d", k), {4'b0, sh_reg_out}, {4'b0, exp_sh(k)});
      check($sformatf("ign_add%0d", k), {3'b0, adder_out}, {3'b0, exp_add(5'b00100, k)});
    end
`ifndef IPC_SINGLE_CYCLE_STEP_EN
    check("rel_e8_add", {3'b0, adder_out}, 8'b0000_0111);
`endif

    // Wrap from 11110.
    reset = 1'b0;
    I     = 5'b11110;
    step();
    check("wrap_rst_sh", {4'b0, sh_reg_out}, 8'b0000_0001);
    check("wrap_rst_add", {3'b0, adder_out}, 8'b0001_1111);
    reset = 1'b1;
    run_checks("wrap", 5'b11110, 8);
`ifndef IPC_SINGLE_CYCLE_STEP_EN
    check("wrap_final", {3'b0, adder_out}, 8'b0000_0001);
`endif

    // Mid-run reset.
    reset = 1'b0;
    I     = 5'b00000;
    step();
    check("mid_rst0_add", {3'b0, adder_out}, 8'b0000_0001);
    reset = 1'b1;
    run_checks("mid_run", 5'b00000, 6);
    I     = 5'b01010;
    reset = 1'b0;
    step();
    check("mid_rst_sh", {4'b0, sh_reg_out}, 8'b0000_0001);
    check("mid_rst_add", {3'b0, adder_out}, 8'b0000_1011);
    reset = 1'b1;
    run_checks("restart", 5'b01010, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_increment_program_counter
